// File: rtl/instr_aligner.sv
// Instruction aligner: turns 32-bit fetch words into one registered RVC/RVI instruction per cycle.
// Define ALIGNER_RVC_EN for compressed support; without it every word is passed through at F.
module instr_aligner (
  input  logic        s_clk_i,
  input  logic        s_rst_i,
  input  logic        s_flush_i,
  input  logic        s_fetch_valid_i,
  output logic        s_fetch_ready_o,
  input  logic [31:0] s_fetch_word_i,
  input  logic [31:0] s_fetch_addr_i,
  input  logic [2:0]  s_fetch_error_i,
  input  logic        s_fetch_pred_i,
  input  logic        s_fetch_predhw_i,
  output logic        s_valid_o,
  input  logic        s_ready_i,
  output logic [31:0] s_instr_o,
  output logic [31:0] s_addr_o,
  output logic [2:0]  s_fetch_error_o,
  output logic        s_align_error_o,
  output logic        s_prediction_o
);
  // Fetch error codes shared with p_hardisc.
  localparam logic [2:0] FETCH_VALID = 3'b000;

  logic        r_valid, w_valid_d;
  logic [31:0] r_instr, w_instr_d;
  logic [31:0] r_addr, w_addr_d;
  logic [2:0]  r_err, w_err_d;
  logic        r_aerr, w_aerr_d;
  logic        r_pred, w_pred_d;
  logic        w_adv, w_ready;

  assign w_adv = ~r_valid | s_ready_i;

`ifdef ALIGNER_RVC_EN
  localparam logic [2:0] FETCH_INCER = 3'b001;

  typedef enum logic [0:0] {StEmpty, StHalf} state_e;

  state_e      r_state, w_state_d;
  logic [15:0] r_hw, w_hw_d;
  logic [31:0] r_haddr, w_haddr_d;
  logic [2:0]  r_herr, w_herr_d;
  logic        r_hpred, w_hpred_d;
  logic [15:0] w_lo, w_hi;
  logic        w_ferr, w_cut, w_hw_rvi;
  logic [31:0] w_addr_p2;

  assign w_lo      = s_fetch_word_i[15:0];
  assign w_hi      = s_fetch_word_i[31:16];
  assign w_ferr    = (s_fetch_error_i != FETCH_VALID) && (s_fetch_error_i != FETCH_INCER);
  // Taken prediction whose instruction ends in the lower halfword.
  assign w_cut     = s_fetch_pred_i & ~s_fetch_predhw_i;
  assign w_hw_rvi  = (r_hw[1:0] == 2'b11);
  assign w_addr_p2 = s_fetch_addr_i + 32'd2;

  always_comb begin
    w_state_d = r_state;
    w_hw_d    = r_hw;
    w_haddr_d = r_haddr;
    w_herr_d  = r_herr;
    w_hpred_d = r_hpred;
    w_valid_d = r_valid;
    w_instr_d = r_instr;
    w_addr_d  = r_addr;
    w_err_d   = r_err;
    w_aerr_d  = r_aerr;
    w_pred_d  = r_pred;
    w_ready   = 1'b0;
    if (s_flush_i) begin
      w_valid_d = 1'b0;
      w_state_d = StEmpty;
    end else if (w_adv) begin
      w_valid_d = 1'b0;
      unique case (r_state)
        StEmpty: begin
          if (s_fetch_valid_i) begin
            w_ready   = 1'b1;
            w_valid_d = 1'b1;
            w_instr_d = s_fetch_word_i;
            w_addr_d  = s_fetch_addr_i;
            w_err_d   = s_fetch_error_i;
            w_aerr_d  = 1'b0;
            w_pred_d  = s_fetch_pred_i;
            if (!w_ferr) begin
              if (!s_fetch_addr_i[1]) begin
                if (w_lo[1:0] != 2'b11) begin
                  w_instr_d = {16'h0, w_lo};
                  w_pred_d  = w_cut;
                  if (!w_cut) begin
                    w_state_d = StHalf;
                    w_hw_d    = w_hi;
                    w_haddr_d = w_addr_p2;
                    w_herr_d  = s_fetch_error_i;
                    w_hpred_d = s_fetch_pred_i;
                  end
                end else begin
                  w_aerr_d = w_cut;
                  w_pred_d = s_fetch_pred_i & s_fetch_predhw_i;
                end
              end else if ((w_hi[1:0] != 2'b11) || s_fetch_pred_i) begin
                w_instr_d = {16'h0, w_hi};
                w_aerr_d  = (w_hi[1:0] == 2'b11);
              end else begin
                w_valid_d = 1'b0;
                w_state_d = StHalf;
                w_hw_d    = w_hi;
                w_haddr_d = s_fetch_addr_i;
                w_herr_d  = s_fetch_error_i;
                w_hpred_d = s_fetch_pred_i;
              end
            end
          end
        end
        StHalf: begin
          // Buffered RVC, predicted-but-split RVI, or a non-contiguous word: flush the buffer out.
          if (!w_hw_rvi || r_hpred ||
              (s_fetch_valid_i && (s_fetch_addr_i != r_haddr + 32'd2))) begin
            w_valid_d = 1'b1;
            w_instr_d = {16'h0, r_hw};
            w_addr_d  = r_haddr;
            w_err_d   = r_herr;
            w_aerr_d  = w_hw_rvi;
            w_pred_d  = r_hpred;
            w_state_d = StEmpty;
          end else if (s_fetch_valid_i) begin
            w_ready   = 1'b1;
            w_valid_d = 1'b1;
            w_instr_d = {w_lo, r_hw};
            w_addr_d  = r_haddr;
            w_err_d   = w_ferr ? s_fetch_error_i : r_herr;
            w_aerr_d  = 1'b0;
            w_pred_d  = w_cut;
            if (w_cut) begin
              w_state_d = StEmpty;
            end else begin
              w_hw_d    = w_hi;
              w_haddr_d = w_addr_p2;
              w_herr_d  = s_fetch_error_i;
              w_hpred_d = s_fetch_pred_i;
            end
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      r_state <= StEmpty;
      r_hw    <= 16'h0;
      r_haddr <= 32'h0;
      r_herr  <= 3'b000;
      r_hpred <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_hw    <= w_hw_d;
      r_haddr <= w_haddr_d;
      r_herr  <= w_herr_d;
      r_hpred <= w_hpred_d;
    end
  end
`else
  logic w_unused;
  assign w_unused = s_fetch_predhw_i;

  always_comb begin
    w_valid_d = r_valid;
    w_instr_d = r_instr;
    w_addr_d  = r_addr;
    w_err_d   = r_err;
    w_aerr_d  = r_aerr;
    w_pred_d  = r_pred;
    w_ready   = 1'b0;
    if (s_flush_i) begin
      w_valid_d = 1'b0;
    end else if (w_adv) begin
      w_valid_d = s_fetch_valid_i;
      w_ready   = s_fetch_valid_i;
      if (s_fetch_valid_i) begin
        w_instr_d = s_fetch_word_i;
        w_addr_d  = s_fetch_addr_i;
        w_err_d   = s_fetch_error_i;
        w_aerr_d  = s_fetch_addr_i[1] | (s_fetch_word_i[1:0] != 2'b11);
        w_pred_d  = s_fetch_pred_i;
      end
    end
  end
`endif

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_addr  <= 32'h0;
      r_err   <= FETCH_VALID;
      r_aerr  <= 1'b0;
      r_pred  <= 1'b0;
    end else begin
      r_valid <= w_valid_d;
      r_instr <= w_instr_d;
      r_addr  <= w_addr_d;
      r_err   <= w_err_d;
      r_aerr  <= w_aerr_d;
      r_pred  <= w_pred_d;
    end
  end

  assign s_fetch_ready_o = w_ready;
  assign s_valid_o       = r_valid;
  assign s_instr_o       = r_instr;
  assign s_addr_o        = r_addr;
  assign s_fetch_error_o = r_err;
  assign s_align_error_o = r_aerr;
  assign s_prediction_o  = r_pred;
endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed scenarios plus random fetch streams against a halfword-level
// reference model; build with or without ALIGNER_RVC_EN to match the DUT.
module tb_instr_aligner;
  localparam logic [2:0] FV = 3'b000;
  localparam logic [2:0] FI = 3'b001;
  localparam logic [2:0] FE = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b0, flush = 1'b0, fvalid = 1'b0, fpred = 1'b0, fpredhw = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] fword = '0, faddr = '0;
  logic [2:0]  ferr = '0;
  logic        fready, valid, aerr, pred;
  logic [31:0] instr, addr;
  logic [2:0]  err;

  always #5 clk = ~clk;

  instr_aligner dut (
    .s_clk_i         (clk),
    .s_rst_i         (rst),
    .s_flush_i       (flush),
    .s_fetch_valid_i (fvalid),
    .s_fetch_ready_o (fready),
    .s_fetch_word_i  (fword),
    .s_fetch_addr_i  (faddr),
    .s_fetch_error_i (ferr),
    .s_fetch_pred_i  (fpred),
    .s_fetch_predhw_i(fpredhw),
    .s_valid_o       (valid),
    .s_ready_i       (ready),
    .s_instr_o       (instr),
    .s_addr_o        (addr),
    .s_fetch_error_o (err),
    .s_align_error_o (aerr),
    .s_prediction_o  (pred)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic obs_ready;

  // Reference model: an optional pending halfword plus the registered output slot.
  typedef struct {logic [15:0] hw; logic [31:0] a; logic [2:0] e; logic p;} half_t;
  half_t pend_q[$], n_pend_q[$];
  logic m_valid = 0, m_aerr = 0, m_pred = 0, n_valid, n_aerr, n_pred, e_ready;
  logic [31:0] m_instr = 0, m_addr = 0, n_instr, n_addr;
  logic [2:0]  m_err = 0, n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [31:0] i, a, input logic [2:0] e, input logic ae, p);
    n_valid = 1; n_instr = i; n_addr = a; n_err = e; n_aerr = ae; n_pred = p;
  endtask

  task automatic model_eval();
    logic adv, cut, bad;
    logic [15:0] lo, hi;
    half_t h;
    n_valid = m_valid; n_instr = m_instr; n_addr = m_addr; n_err = m_err;
    n_aerr = m_aerr; n_pred = m_pred; n_pend_q = pend_q; e_ready = 0;
    adv = !m_valid || ready;
    lo = fword[15:0];
    hi = fword[31:16];
    cut = fpred && !fpredhw;
    bad = (ferr != FV) && (ferr != FI);
    if (flush) begin
      n_valid = 0;
      n_pend_q = {};
    end else if (adv) begin
      n_valid = 0;
`ifdef ALIGNER_RVC_EN
      if (pend_q.size() != 0) begin
        h = pend_q[0];
        if (h.hw[1:0] != 2'b11 || h.p || (fvalid && faddr != h.a + 2)) begin
          emit({16'h0, h.hw}, h.a, h.e, h.hw[1:0] == 2'b11, h.p);
          n_pend_q = {};
        end else if (fvalid) begin
          e_ready = 1;
          emit({lo, h.hw}, h.a, bad ? ferr : h.e, 0, cut);
          n_pend_q = {};
          if (!cut) n_pend_q.push_back('{hi, faddr + 2, ferr, fpred});
        end
      end else if (fvalid) begin
        e_ready = 1;
        if (bad) emit(fword, faddr, ferr, 0, fpred);
        else if (!faddr[1]) begin
          if (lo[1:0] != 2'b11) begin
            emit({16'h0, lo}, faddr, ferr, 0, cut);
            if (!cut) n_pend_q.push_back('{hi, faddr + 2, ferr, fpred});
          end else emit(fword, faddr, ferr, cut, fpred && fpredhw);
        end else if (hi[1:0] != 2'b11 || fpred) begin
          emit({16'h0, hi}, faddr, ferr, hi[1:0] == 2'b11, fpred);
        end else n_pend_q.push_back('{hi, faddr, ferr, 1'b0});
      end
`else
      e_ready = fvalid;
      if (fvalid) emit(fword, faddr, ferr, faddr[1] || lo[1:0] != 2'b11, fpred);
`endif
    end
    if (rst) begin
      n_valid = 0; n_instr = 0; n_addr = 0; n_err = FV; n_aerr = 0; n_pred = 0;
      n_pend_q = {};
    end
  endtask

  task automatic step(input logic r, f, v, input logic [31:0] w, a, input logic [2:0] e,
                      input logic p, ph, rdy);
    rst = r; flush = f; fvalid = v; fword = w; faddr = a; ferr = e;
    fpred = p; fpredhw = ph; ready = rdy;
    model_eval();
    #1;
    obs_ready = fready;
    check("fetch_ready", 32'(fready), 32'(e_ready));
    @(posedge clk);
    #1;
    m_valid = n_valid; m_instr = n_instr; m_addr = n_addr; m_err = n_err;
    m_aerr = n_aerr; m_pred = n_pred; pend_q = n_pend_q;
    check("valid", 32'(valid), 32'(m_valid));
    if (m_valid || r) begin
      check("instr", instr, m_instr);
      check("addr", addr, m_addr);
      check("error", 32'(err), 32'(m_err));
      check("align_error", 32'(aerr), 32'(m_aerr));
      check("prediction", 32'(pred), 32'(m_pred));
    end
  endtask

  function automatic logic [15:0] gen_hw();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(0, 1) == 0) h[1:0] = 2'b11;
    return h;
  endfunction

  initial begin
    logic [31:0] cw, ca;
    logic [2:0]  ce;
    logic        cp, cph, cv;
    @(posedge clk);
    #1;
    // Reset state
    step(1, 0, 0, 0, 0, FV, 0, 0, 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_instr", instr, 0);
    check("rst_err", 32'(err), 32'(FV));
    // Aligned RVI
    step(0, 0, 1, 32'h00A00093, 32'h100, FV, 0, 0, 1);
    check("rvi_instr", instr, 32'h00A00093);
    check("rvi_addr", addr, 32'h100);
    check("rvi_aerr", 32'(aerr), 0);
    // Fetch error word passes through unchanged
    step(0, 0, 1, 32'h00A00093, 32'h500, FE, 0, 0, 1);
    check("ferr_err", 32'(err), 32'(FE));
    check("ferr_addr", addr, 32'h500);
    // Stall: outputs stay put for three cycles
    step(0, 0, 1, 32'h00A00093, 32'h600, FV, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h11111113, 32'h604, FV, 0, 0, 0);
      check("stall_ready", 32'(obs_ready), 0);
      check("stall_instr", instr, 32'h00A00093);
      check("stall_addr", addr, 32'h600);
    end
    step(0, 0, 0, 0, 0, FV, 0, 0, 1);
`ifdef ALIGNER_RVC_EN
    // RVC then split RVI
    step(0, 0, 1, 32'h00930505, 32'h200, FV, 0, 0, 1);
    check("rvc_instr", instr, 32'h00000505);
    check("rvc_addr", addr, 32'h200);
    step(0, 0, 1, 32'h0000000A, 32'h204, FV, 0, 0, 1);
    check("split_instr", instr, 32'h000A0093);
    check("split_addr", addr, 32'h202);
    step(0, 0, 0, 0, 0, FV, 0, 0, 1);
    check("buf_instr", instr, 32'h0);
    check("buf_addr", addr, 32'h206);
    // Address mismatch while half-buffered
    step(0, 0, 1, 32'h00930505, 32'h204, FV, 0, 0, 1);
    step(0, 0, 1, 32'h00A00093, 32'h300, FV, 0, 0, 1);
    check("mis_ready", 32'(obs_ready), 0);
    check("mis_instr", instr, 32'h00000093);
    check("mis_aerr", 32'(aerr), 1);
    step(0, 0, 1, 32'h00A00093, 32'h300, FV, 0, 0, 1);
    check("mis_next_ready", 32'(obs_ready), 1);
    check("mis_next_addr", addr, 32'h300);
    // Prediction on lower RVC drops the upper halfword
    step(0, 0, 1, 32'hA0010505, 32'h400, FV, 1, 0, 1);
    check("pred_flag", 32'(pred), 1);
    check("pred_instr", instr, 32'h00000505);
    step(0, 0, 0, 0, 0, FV, 0, 0, 1);
    check("pred_drop", 32'(valid), 0);
    // Flush while half-buffered
    step(0, 0, 1, 32'h00930505, 32'h700, FV, 0, 0, 1);
    step(0, 1, 1, 32'h00000013, 32'h704, FV, 0, 0, 1);
    check("flush_valid", 32'(valid), 0);
    step(0, 0, 1, 32'h00A00093, 32'h800, FV, 0, 0, 1);
    check("flush_empty_addr", addr, 32'h800);
    check("flush_empty_aerr", 32'(aerr), 0);
    // Reset mid-stream loses the buffered halfword
    step(0, 0, 1, 32'h05050505, 32'h900, FV, 0, 0, 1);
    step(1, 0, 0, 0, 0, FV, 0, 0, 1);
    check("rst2_addr", addr, 0);
    step(0, 0, 0, 0, 0, FV, 0, 0, 1);
    check("rst2_lost", 32'(valid), 0);
`else
    step(0, 0, 1, 32'h00A00093, 32'h502, FV, 0, 0, 1);
    check("upper_aerr", 32'(aerr), 1);
    step(0, 0, 1, 32'h00930505, 32'h200, FV, 0, 0, 1);
    check("rvc_aerr", 32'(aerr), 1);
    check("rvc_instr", instr, 32'h00930505);
    step(0, 1, 1, 32'h00A00093, 32'h204, FV, 0, 0, 1);
    check("flush_ready", 32'(obs_ready), 0);
    check("flush_valid", 32'(valid), 0);
    step(1, 0, 1, 32'h00A00093, 32'h208, FV, 0, 0, 1);
    check("rst2_valid", 32'(valid), 0);
`endif
    // Random streams: a word is held until consumed, addresses mostly sequential
    cw = {gen_hw(), gen_hw()}; ca = 32'h1000; ce = FV; cp = 0; cph = 0; cv = 1;
    for (int i = 0; i < 600; i++) begin
      logic r, f;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 39) == 0);
      step(r, f, cv, cw, ca, ce, cp, cph, $urandom_range(0, 3) != 0);
      if (obs_ready || f || !cv) begin
        if ($urandom_range(0, 7) == 0) ca = $urandom & 32'h0000_0ffe;
        else if (obs_ready) ca = {ca[31:2], 2'b00} + 32'd4;
        cw = {gen_hw(), gen_hw()};
        case ($urandom_range(0, 15))
          0:       ce = FE;
          1:       ce = FI;
          default: ce = FV;
        endcase
        cp  = ($urandom_range(0, 7) == 0);
        cph = 1'($urandom_range(0, 1));
      end
      cv = ($urandom_range(0, 3) != 0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
